uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
UART receive end paired with the team's transmitter. Frame format: 1 start bit (low), 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit (high). The receiver oversamples the serial line on a 16x-baud clock-enable strobe, rebuilds the byte, checks parity and stop, and holds the result for a simple ready/read handshake toward the host logic.

Parameters:
OVERSAMPLE, 16, clken ticks per bit period. Must be a power of two and at least 8.
MID_SAMPLE, 8, tick index within a bit at which rx is sampled. Must be less than OVERSAMPLE.

Ports:
clk_50m  input  1  system clock; all logic on its rising edge
rst_n  input  1  reset, asynchronous, active-low
rx  input  1  serial line, asynchronous to clk_50m, idles high
clken  input  1  single-cycle strobe at OVERSAMPLE x baud
rd_en  input  1  host read strobe; clears rdy and all error flags
dout  output  8  last received byte
rdy  output  1  a byte is held in dout and has not yet been read
parity_err  output  1  parity of the held byte failed
frame_err  output  1  stop bit of the held byte sampled low
overrun  output  1  a new byte was committed while rdy was already 1

Behaviour:
- Reset (async, rst_n=0): dout=8'h00; rdy, parity_err, frame_err, overrun=0; state=IDLE; sample counter and bit counter=0; synchronizer flops=1.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
- The sample counter (log2(OVERSAMPLE) bits) advances only on cycles with clken=1 and wraps at OVERSAMPLE-1 to 0. When clken=0, no state changes.
- IDLE: on a clken tick with rx_s=0, go to START and set the sample counter to 0.
- START: when the counter reaches MID_SAMPLE, check rx_s.
  - rx_s=1 means a glitch: return to IDLE with nothing reported.
  - rx_s=0: reset the counter to MID_SAMPLE alignment, so later samples fall at mid-bit every OVERSAMPLE ticks, and go to DATA with bit counter 0.
- DATA: at each mid-bit sample, shift rx_s into shreg[bitcnt] (LSB first). After bit 7, go to PARITY.
- PARITY: at mid-bit, store the parity sample. par_bad = (XOR of shreg) ^ sample. Go to STOP.
- STOP: at mid-bit, commit the frame:
  - dout<=shreg
  - parity_err<=par_bad
  - frame_err<=~rx_s
  - rdy<=1
  - overrun<=1 if rdy was already 1 and rd_en=0 that cycle; otherwise overrun keeps its value.
  - Then go to IDLE if rx_s=1. If rx_s=0 (break or framing error), go to WAIT_HIGH.
- WAIT_HIGH: stay until a clken tick sees rx_s=1, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- Latency: rdy rises on the clk_50m edge after the stop-bit mid-sample tick. dout and the error flags are valid on the same edge as rdy.
- rd_en=1 with no commit that cycle: rdy, parity_err, frame_err, overrun all go to 0. dout is held.
- rd_en and commit in the same cycle: the commit wins. rdy=1, flags take the new frame's values, overrun=0.
- An overrun overwrites dout with the newer byte. overrun is sticky until rd_en.
- rst_n asserted mid-frame: immediate return to the reset state; the partial byte is discarded.
- Only ticks are counted, so baud rate = clken rate / OVERSAMPLE.

Test Plan:
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), parity 0, stop 1, 16 clken per bit -> rdy=1, dout=8'hA5, parity_err=0, frame_err=0, one cycle after the stop mid-sample.
- Frame 0x01 with parity bit 0 (correct is 1) -> dout=8'h01, rdy=1, parity_err=1; then pulse rd_en -> rdy=0, parity_err=0, dout still 8'h01.
- rx low for 4 clken ticks then high (glitch) -> state returns to IDLE; rdy stays 0; a following valid 0x3C frame is received correctly.
- Frame 0x7E with stop bit 0, line held low for 40 ticks then high -> frame_err=1, dout=8'h7E; no second byte is reported during the low period.
- Two frames 0x11 then 0x22 with no rd_en -> dout=8'h22, rdy=1, overrun=1. Repeat with rd_en in the same cycle as the second commit -> overrun=0, rdy=1.
- rst_n pulsed low during DATA bit 4 of 0xFF -> all outputs 0 immediately; the next 0x55 frame is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive end: 16x oversampled 8E1 frames, parity/stop checking and a
// ready/read handshake toward the host.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int MID_SAMPLE = 8
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clken,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int            CW  = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID = CW'(MID_SAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_s;
    logic [CW-1:0]   samp_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bad;
    logic            mid;
    logic            cnt_clr, bit_clr, shift_en, par_en, commit;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Once START is entered with the counter at 0, every later hit of MID is a
    // mid-bit point; the power-of-two counter wraps on its own.
    assign mid = clken && (samp_cnt == MID);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (clken && !rx_s)        state_nxt = START;
            START:     if (mid)                   state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (mid && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:    if (mid)                   state_nxt = STOP;
            STOP:      if (mid)                   state_nxt = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (clken && rx_s)         state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = (state == IDLE);
        bit_clr  = (state == START)  && mid;
        shift_en = (state == DATA)   && mid;
        par_en   = (state == PARITY) && mid;
        commit   = (state == STOP)   && mid;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)      samp_cnt <= '0;
        else if (clken)  samp_cnt <= cnt_clr ? '0 : samp_cnt + 1'b1;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            par_bad <= 1'b0;
        end else begin
            if (bit_clr) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                shreg[bit_cnt] <= rx_s;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            if (par_en) par_bad <= (^shreg) ^ rx_s;
        end
    end

    // A commit outranks a simultaneous read: the new frame is what the host sees next.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 8'h00;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            dout       <= shreg;
            parity_err <= par_bad;
            frame_err  <= ~rx_s;
            rdy        <= 1'b1;
            if (rd_en)    overrun <= 1'b0;
            else if (rdy) overrun <= 1'b1;
        end else if (rd_en) begin
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: clken every 4 clocks, frames driven bit by bit.
module tb_uart_receiver;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       clken   = 1'b0;
    logic       rd_en   = 1'b0;
    logic [7:0] dout;
    logic       rdy, parity_err, frame_err, overrun;

    int n_vec = 0;
    int n_err = 0;

    uart_receiver #(.OVERSAMPLE(16), .MID_SAMPLE(8)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .rx         (rx),
        .clken      (clken),
        .rd_en      (rd_en),
        .dout       (dout),
        .rdy        (rdy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #10 clk_50m = ~clk_50m;

    initial begin
        forever begin
            repeat (3) @(posedge clk_50m);
            #1 clken = 1'b1;
            @(posedge clk_50m);
            #1 clken = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after the n-th edge that the DUT saw with clken=1.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk_50m); while (!clken);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    // Drives start, data, parity and the stop level, then stops one tick
    // short of the stop-bit mid-sample.
    task automatic send_head(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        rx = stop;
        wait_ticks(9);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par);
        send_head(d, par, 1'b1);
        wait_ticks(7);
    endtask

    task automatic rd_pulse;
        rd_en = 1'b1;
        @(posedge clk_50m);
        #1 rd_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_50m);
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Basic frame: rdy must rise exactly on the stop mid-sample edge.
        send_head(8'hA5, 1'b0, 1'b1);
        chk("a5_pre_rdy", rdy, 1'b0);
        wait_ticks(1);
        chk("a5_rdy", rdy, 1'b1);
        chk("a5_dout", dout, 8'hA5);
        chk("a5_perr", parity_err, 1'b0);
        chk("a5_ferr", frame_err, 1'b0);
        chk("a5_ovr", overrun, 1'b0);
        wait_ticks(6);
        rd_pulse();
        chk("a5_rd_rdy", rdy, 1'b0);

        // Wrong parity, then a read clears the flags but keeps the byte.
        send_frame(8'h01, 1'b0);
        chk("p01_dout", dout, 8'h01);
        chk("p01_rdy", rdy, 1'b1);
        chk("p01_perr", parity_err, 1'b1);
        chk("p01_ferr", frame_err, 1'b0);
        rd_pulse();
        chk("p01_rd_rdy", rdy, 1'b0);
        chk("p01_rd_perr", parity_err, 1'b0);
        chk("p01_rd_dout", dout, 8'h01);

        // Short low glitch is rejected at the start-bit mid-sample.
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(32);
        chk("glitch_rdy", rdy, 1'b0);
        send_frame(8'h3C, 1'b0);
        chk("g3c_dout", dout, 8'h3C);
        chk("g3c_rdy", rdy, 1'b1);
        chk("g3c_perr", parity_err, 1'b0);
        rd_pulse();

        // Stop bit low with the line held low: one frame only.
        send_head(8'h7E, 1'b0, 1'b0);
        wait_ticks(1);
        chk("f7e_ferr", frame_err, 1'b1);
        chk("f7e_dout", dout, 8'h7E);
        chk("f7e_rdy", rdy, 1'b1);
        chk("f7e_perr", parity_err, 1'b0);
        rd_pulse();
        chk("f7e_rd_rdy", rdy, 1'b0);
        chk("f7e_rd_ferr", frame_err, 1'b0);
        wait_ticks(30);
        rx = 1'b1;
        wait_ticks(200);
        chk("f7e_no_2nd", rdy, 1'b0);

        // Back-to-back frames without a read.
        send_frame(8'h11, 1'b0);
        chk("o11_rdy", rdy, 1'b1);
        chk("o11_ovr", overrun, 1'b0);
        send_frame(8'h22, 1'b0);
        chk("o22_dout", dout, 8'h22);
        chk("o22_rdy", rdy, 1'b1);
        chk("o22_ovr", overrun, 1'b1);
        rd_pulse();
        chk("o_rd_ovr", overrun, 1'b0);
        chk("o_rd_rdy", rdy, 1'b0);

        // Same again, with the read landing on the second commit edge.
        send_frame(8'h11, 1'b0);
        send_head(8'h22, 1'b0, 1'b1);
        repeat (3) @(posedge clk_50m);
        #1 rd_en = 1'b1;
        @(posedge clk_50m);
        #1 rd_en = 1'b0;
        chk("c22_rdy", rdy, 1'b1);
        chk("c22_ovr", overrun, 1'b0);
        chk("c22_dout", dout, 8'h22);
        wait_ticks(6);

        // Async reset in the middle of data bit 4 of 0xFF, with a byte still held.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        wait_ticks(5);
        rst_n = 1'b0;
        #2;
        chk("r_dout", dout, 8'h00);
        chk("r_rdy", rdy, 1'b0);
        chk("r_ovr", overrun, 1'b0);
        @(posedge clk_50m);
        #1 rst_n = 1'b1;
        wait_ticks(200);
        chk("r_idle_rdy", rdy, 1'b0);
        send_frame(8'h55, 1'b0);
        chk("r55_dout", dout, 8'h55);
        chk("r55_rdy", rdy, 1'b1);
        chk("r55_perr", parity_err, 1'b0);
        chk("r55_ferr", frame_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
